// File: rtl/rf_write_arbiter_if.sv
// Handshake bundle between the pipeline/mul-div side (master) and the RF write arbiter (slave).
interface rf_write_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              wb_regwrite;
  logic [ADDR_W-1:0] wb_write_reg;
  logic [DATA_W-1:0] wb_write_data;
  logic              md_valid;
  logic [ADDR_W-1:0] md_reg;
  logic [DATA_W-1:0] md_data;
  logic              md_ready;
  logic [ADDR_W-1:0] id_rs;
  logic [ADDR_W-1:0] id_rt;
  logic              id_pend_hit;
  logic              pipe_stall;
  logic              rf_regwrite;
  logic [ADDR_W-1:0] rf_write_reg;
  logic [DATA_W-1:0] rf_write_data;

  modport master (
    output wb_regwrite, wb_write_reg, wb_write_data,
    output md_valid, md_reg, md_data,
    output id_rs, id_rt,
    input  md_ready, id_pend_hit, pipe_stall,
    input  rf_regwrite, rf_write_reg, rf_write_data
  );

  modport slave (
    input  wb_regwrite, wb_write_reg, wb_write_data,
    input  md_valid, md_reg, md_data,
    input  id_rs, id_rt,
    output md_ready, id_pend_hit, pipe_stall,
    output rf_regwrite, rf_write_reg, rf_write_data
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single RF write port between WB and a queued mul/div result stream.
// Optional macro RFARB_PERF_EN adds saturating stall/full performance counters.
module rf_write_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef RFARB_PERF_EN
  output logic [15:0] perf_stall_cnt,
  output logic [15:0] perf_full_cnt,
`endif
  rf_write_arbiter_if.slave arb
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int PTR_W  = IDX_W + 1;
  localparam int SCNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [SCNT_W-1:0] STARVE_TOP = SCNT_W'(STARVE_MAX);

  logic [ADDR_W-1:0] reg_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [SCNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic              pipe_stall_q, pipe_stall_d;

  logic              empty, full;
  logic              pop, push, bypass, grant;
  logic [ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;
  logic [PTR_W-1:0]  count;
  logic [IDX_W-1:0]  offset;
  logic              pend_hit;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                 (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);

  // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latch).
  always_comb begin
    pop      = 1'b0;
    bypass   = 1'b0;
    grant    = 1'b0;
    sel_reg  = '0;
    sel_data = '0;
    if (arb.wb_regwrite) begin
      grant    = 1'b1;
      sel_reg  = arb.wb_write_reg;
      sel_data = arb.wb_write_data;
    end else if (!empty) begin
      grant    = 1'b1;
      pop      = 1'b1;
      sel_reg  = reg_mem[rd_ptr_q[IDX_W-1:0]];
      sel_data = data_mem[rd_ptr_q[IDX_W-1:0]];
    end else if (arb.md_valid) begin
      grant    = 1'b1;
      bypass   = 1'b1;
      sel_reg  = arb.md_reg;
      sel_data = arb.md_data;
    end
    push = arb.md_valid && !full && !bypass;
  end

  // Register 0 is a legal destination that still consumes a slot, but is never written.
  assign arb.rf_regwrite   = rst_n && grant && (sel_reg != '0);
  assign arb.rf_write_reg  = sel_reg;
  assign arb.rf_write_data = sel_data;
  assign arb.md_ready      = !full;
  assign arb.pipe_stall    = pipe_stall_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + (push ? PTR_W'(1) : PTR_W'(0));
    rd_ptr_d = rd_ptr_q + (pop  ? PTR_W'(1) : PTR_W'(0));

    starve_cnt_d = starve_cnt_q;
    if (empty || pop) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != STARVE_TOP) begin
      starve_cnt_d = starve_cnt_q + SCNT_W'(1);
    end

    pipe_stall_d = (starve_cnt_q == STARVE_TOP) && !pipe_stall_q && !empty;
  end

  // Entry i is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    pend_hit = 1'b0;
    offset   = '0;
    count    = wr_ptr_q - rd_ptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      offset = IDX_W'(i) - rd_ptr_q[IDX_W-1:0];
      if (({1'b0, offset} < count) &&
          (((arb.id_rs != '0) && (reg_mem[i] == arb.id_rs)) ||
           ((arb.id_rt != '0) && (reg_mem[i] == arb.id_rt)))) begin
        pend_hit = 1'b1;
      end
    end
  end

  assign arb.id_pend_hit = pend_hit;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      starve_cnt_q <= '0;
      pipe_stall_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      starve_cnt_q <= starve_cnt_d;
      pipe_stall_q <= pipe_stall_d;
    end
  end

  // NOTE: the payload storage is not reset; pointer reset alone makes every entry invalid.
  always_ff @(posedge clk) begin
    if (push) begin
      reg_mem[wr_ptr_q[IDX_W-1:0]]  <= arb.md_reg;
      data_mem[wr_ptr_q[IDX_W-1:0]] <= arb.md_data;
    end
  end

`ifdef RFARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_full_cnt  <= '0;
    end else begin
      if (pipe_stall_q && (perf_stall_cnt != 16'hFFFF)) perf_stall_cnt <= perf_stall_cnt + 16'd1;
      if (full && (perf_full_cnt != 16'hFFFF))          perf_full_cnt  <= perf_full_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: bypass, FIFO fill, forced drain, reg-0 handling, async reset.
module tb_rf_write_arbiter;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  rf_write_arbiter_if #(.DATA_W(32), .ADDR_W(5)) arb_if ();

`ifdef RFARB_PERF_EN
  logic [15:0] perf_stall_cnt;
  logic [15:0] perf_full_cnt;
`endif

  rf_write_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef RFARB_PERF_EN
    .perf_stall_cnt (perf_stall_cnt),
    .perf_full_cnt  (perf_full_cnt),
`endif
    .arb   (arb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; checks follow 1 ns later, well away from the rising edge.
  task automatic drive(input logic wb, input logic [4:0] wreg, input logic [31:0] wdata,
                       input logic mv, input logic [4:0] mreg, input logic [31:0] mdata,
                       input logic [4:0] rs, input logic [4:0] rt);
    @(negedge clk);
    arb_if.wb_regwrite   = wb;
    arb_if.wb_write_reg  = wreg;
    arb_if.wb_write_data = wdata;
    arb_if.md_valid      = mv;
    arb_if.md_reg        = mreg;
    arb_if.md_data       = mdata;
    arb_if.id_rs         = rs;
    arb_if.id_rt         = rt;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    arb_if.wb_regwrite   = 1'b0;
    arb_if.wb_write_reg  = '0;
    arb_if.wb_write_data = '0;
    arb_if.md_valid      = 1'b0;
    arb_if.md_reg        = '0;
    arb_if.md_data       = '0;
    arb_if.id_rs         = '0;
    arb_if.id_rt         = '0;
    #1;
    check("rst_md_ready",   arb_if.md_ready,      1);
    check("rst_pipe_stall", arb_if.pipe_stall,    0);
    check("rst_regwrite",   arb_if.rf_regwrite,   0);
    check("rst_write_reg",  arb_if.rf_write_reg,  0);
    check("rst_write_data", arb_if.rf_write_data, 0);
    check("rst_pend_hit",   arb_if.id_pend_hit,   0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: bypass with WB idle and an empty FIFO
    drive(0, 0, 0, 1, 5'd7, 32'h55, 0, 0);
    check("byp_regwrite", arb_if.rf_regwrite,   1);
    check("byp_reg",      arb_if.rf_write_reg,  7);
    check("byp_data",     arb_if.rf_write_data, 32'h55);
    drive(0, 0, 0, 0, 0, 0, 5'd7, 0);
    check("byp_not_queued_write", arb_if.rf_regwrite, 0);
    check("byp_not_queued_hit",   arb_if.id_pend_hit, 0);

    // 2: WB busy every cycle, four mul/div pushes of regs 1..4
    for (int i = 1; i <= 4; i++) begin
      drive(1, 5'(10 + i), 32'hA000 + i, 1, 5'(i), 32'h100 + i, 0, 0);
      check("fill_wb_reg",   arb_if.rf_write_reg,  10 + i);
      check("fill_wb_data",  arb_if.rf_write_data, 32'hA000 + i);
      check("fill_md_ready", arb_if.md_ready,      1);
    end
    drive(1, 5'd20, 32'hA020, 0, 0, 0, 5'd3, 0);
    check("full_md_ready", arb_if.md_ready,    0);
    check("full_pend_hit", arb_if.id_pend_hit, 1);
    check("pre_stall",     arb_if.pipe_stall,  0);

    // 3: stall appears; WB goes idle that cycle and reg 1 drains
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("stall_high",     arb_if.pipe_stall,    1);
    check("drain_regwrite", arb_if.rf_regwrite,   1);
    check("drain_reg",      arb_if.rf_write_reg,  1);
    check("drain_data",     arb_if.rf_write_data, 32'h101);

    // WB busy again while a reg-0 result is queued, refilling the FIFO
    drive(1, 5'd21, 32'hA021, 1, 5'd0, 32'hAA, 0, 0);
    check("stall_one_cycle", arb_if.pipe_stall,     0);
    check("starve_cleared",  dut.starve_cnt_q,       0);
    check("refill_ready",    arb_if.md_ready,        1);

    // 4: full FIFO, WB idle, md_valid -> head popped, no push
    drive(0, 0, 0, 1, 5'd9, 32'h99, 0, 0);
    check("fullpop_ready", arb_if.md_ready,      0);
    check("fullpop_reg",   arb_if.rf_write_reg,  2);
    check("fullpop_data",  arb_if.rf_write_data, 32'h102);
    drive(0, 0, 0, 0, 0, 0, 5'd9, 5'd0);
    check("after_pop_ready", arb_if.md_ready,     1);
    check("no_push_hit",     arb_if.id_pend_hit,  0);
    check("pop3_reg",        arb_if.rf_write_reg, 3);
    check("no_stall",        arb_if.pipe_stall,   0);
    drive(0, 0, 0, 0, 0, 0, 5'd0, 5'd4);
    check("pop4_reg",       arb_if.rf_write_reg, 4);
    check("popping_hit",    arb_if.id_pend_hit,  1);

    // 5: reg-0 entry drains without writing and never raises the hit
    drive(0, 0, 0, 0, 0, 0, 5'd0, 5'd0);
    check("reg0_regwrite", arb_if.rf_regwrite, 0);
    check("reg0_hit",      arb_if.id_pend_hit, 0);
    check("reg0_data",     arb_if.rf_write_data, 32'hAA);
    drive(0, 0, 0, 1, 5'd5, 32'h5, 0, 0);
    check("empty_bypass_we",  arb_if.rf_regwrite,  1);
    check("empty_bypass_reg", arb_if.rf_write_reg, 5);

    // 6: two entries queued, then asynchronous reset mid-cycle
    drive(1, 5'd22, 32'hA022, 1, 5'd6, 32'h66, 0, 0);
    drive(1, 5'd23, 32'hA023, 1, 5'd8, 32'h88, 0, 0);
    drive(1, 5'd24, 32'hA024, 0, 0, 0, 5'd6, 5'd8);
    check("queued_hit", arb_if.id_pend_hit, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_md_ready",   arb_if.md_ready,    1);
    check("arst_pend_hit",   arb_if.id_pend_hit, 0);
    check("arst_pipe_stall", arb_if.pipe_stall,  0);
    check("arst_no_write",   arb_if.rf_regwrite, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("post_rst_regwrite", arb_if.rf_regwrite,  0);
    check("post_rst_reg",      arb_if.rf_write_reg, 0);
    drive(0, 0, 0, 1, 5'd3, 32'h33, 0, 0);
    check("post_rst_bypass", arb_if.rf_write_reg,  3);
    check("post_rst_data",   arb_if.rf_write_data, 32'h33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
